// File: rtl/dp1m4_row_ctrl.sv
// dp1m4_row_ctrl: sequences one row job.
// Job order: weight fetch, row load, activation stream, pipeline drain,
// then result handoff.
module dp1m4_row_ctrl #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 20,
    parameter int unsigned nnz     = 2,
    parameter int unsigned n       = 4,
    parameter int unsigned M       = 4,
    parameter int unsigned LAT     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             num_steps,
    input  logic                   accumulate,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [M*nnz*bw-1:0]    w_data,
    input  logic [M*n-1:0]         w_idx,
    input  logic [M-1:0]           w_sel,
    input  logic [M*4-1:0]         w_aidx,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [2*bw-1:0]        act_data,
    output logic                   row_load,
    output logic                   row_execute,
    output logic [2*bw-1:0]        row_activation_flat,
    output logic [M-1:0]           row_a_select,
    output logic [M*nnz*bw-1:0]    row_weights_flat,
    output logic [M*n-1:0]         row_w_index,
    output logic [M*4-1:0]         row_activation_index_flat,
    output logic [M*psum_bw-1:0]   row_psum_in,
    input  logic [M*psum_bw-1:0]   row_psum_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [M*psum_bw-1:0]   res_data
);

    // Drain counter only needs to reach LAT-1 (LAT is at least 1).
    localparam int unsigned DCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t         state;
    logic [7:0]     steps_q;
    logic [7:0]     step_cnt;
    logic [DCW-1:0] drain_cnt;

    // Handshake readies and the execute path follow state and act_valid directly.
    assign w_ready             = (state == WREQ);
    assign act_ready           = (state == EXEC);
    assign row_execute         = (state == EXEC) && act_valid;
    assign row_activation_flat = row_execute ? act_data : '0;

    // Job sequencer with registered status, holding registers and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= IDLE;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            row_load                  <= 1'b0;
            res_valid                 <= 1'b0;
            res_data                  <= '0;
            row_psum_in               <= '0;
            row_a_select              <= '0;
            row_weights_flat          <= '0;
            row_w_index               <= '0;
            row_activation_index_flat <= '0;
            steps_q                   <= '0;
            step_cnt                  <= '0;
            drain_cnt                 <= '0;
        end else begin
            done     <= 1'b0;
            row_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_steps != 8'd0) begin
                            state    <= WREQ;
                            busy     <= 1'b1;
                            steps_q  <= num_steps;
                            step_cnt <= '0;
                            // psum feed is frozen for the whole job, so the new
                            // result landing in res_data cannot disturb it.
                            row_psum_in <= accumulate ? res_data : '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WREQ: begin
                    if (w_valid) begin
                        row_weights_flat          <= w_data;
                        row_w_index               <= w_idx;
                        row_a_select              <= w_sel;
                        row_activation_index_flat <= w_aidx;
                        row_load                  <= 1'b1;
                        state                     <= LOAD;
                    end
                end
                LOAD: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (act_valid) begin
                        if (step_cnt == steps_q - 8'd1) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            step_cnt <= step_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        res_data  <= row_psum_out;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp1m4_row_ctrl.sv
// Directed self-checking bench for dp1m4_row_ctrl.
module tb_dp1m4_row_ctrl;

    localparam int unsigned BW  = 4;
    localparam int unsigned PBW = 20;
    localparam int unsigned NNZ = 2;
    localparam int unsigned NI  = 4;
    localparam int unsigned ML  = 4;
    localparam int unsigned LT  = 2;
    localparam int unsigned WDW = ML*NNZ*BW;
    localparam int unsigned WIW = ML*NI;
    localparam int unsigned AIW = ML*4;
    localparam int unsigned PSW = ML*PBW;
    localparam int unsigned AW  = 2*BW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     num_steps;
    logic           accumulate;
    logic           busy, done;
    logic           w_valid, w_ready;
    logic [WDW-1:0] w_data;
    logic [WIW-1:0] w_idx;
    logic [ML-1:0]  w_sel;
    logic [AIW-1:0] w_aidx;
    logic           act_valid, act_ready;
    logic [AW-1:0]  act_data;
    logic           row_load, row_execute;
    logic [AW-1:0]  row_activation_flat;
    logic [ML-1:0]  row_a_select;
    logic [WDW-1:0] row_weights_flat;
    logic [WIW-1:0] row_w_index;
    logic [AIW-1:0] row_activation_index_flat;
    logic [PSW-1:0] row_psum_in, row_psum_out;
    logic           res_valid, res_ready;
    logic [PSW-1:0] res_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WDW-1:0] exp_wd;
    logic [WIW-1:0] exp_wi;
    logic [ML-1:0]  exp_ws;
    logic [AIW-1:0] exp_wa;
    logic [PSW-1:0] p1, p2, p3, p4, p5;

    dp1m4_row_ctrl #(
        .bw(BW), .psum_bw(PBW), .nnz(NNZ), .n(NI), .M(ML), .LAT(LT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
        .accumulate(accumulate), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
        .w_sel(w_sel), .w_aidx(w_aidx),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .row_load(row_load), .row_execute(row_execute),
        .row_activation_flat(row_activation_flat), .row_a_select(row_a_select),
        .row_weights_flat(row_weights_flat), .row_w_index(row_w_index),
        .row_activation_index_flat(row_activation_index_flat),
        .row_psum_in(row_psum_in), .row_psum_out(row_psum_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_wd"}, 128'(row_weights_flat), 128'(exp_wd));
        chk({tag, "_wi"}, 128'(row_w_index), 128'(exp_wi));
        chk({tag, "_ws"}, 128'(row_a_select), 128'(exp_ws));
        chk({tag, "_wa"}, 128'(row_activation_index_flat), 128'(exp_wa));
    endtask

    // One job: cycle 0 start, cycle 1 weight handshake, cycle 2 load, then
    // EXEC with an optional stall window, LAT drain cycles, and OUT.
    task automatic run_job(input int steps, input bit acc, input int stall_at,
                           input int stall_len, input int rdy_wait,
                           input logic [PSW-1:0] psum, input logic [PSW-1:0] exp_pin,
                           input bit poke);
        int execs;
        int stalled;
        int cyc;
        exp_wd = WDW'($urandom);
        exp_wi = WIW'($urandom);
        exp_ws = ML'($urandom);
        exp_wa = AIW'($urandom);
        w_data = exp_wd; w_idx = exp_wi; w_sel = exp_ws; w_aidx = exp_wa;
        start = 1'b1; num_steps = 8'(steps); accumulate = acc;
        w_valid = 1'b1; act_valid = 1'b0; res_ready = 1'b0; row_psum_out = psum;
        tick();
        start = 1'b0; num_steps = 8'd0; accumulate = 1'b0;
        chk("wreq_busy", 128'(busy), 128'(1));
        chk("wreq_w_ready", 128'(w_ready), 128'(1));
        chk("wreq_no_load", 128'(row_load), 128'(0));
        tick();
        w_valid = 1'b0;
        w_data = ~exp_wd; w_idx = ~exp_wi; w_sel = ~exp_ws; w_aidx = ~exp_wa;
        #1;
        chk("load_strobe", 128'(row_load), 128'(1));
        chk("load_no_exec", 128'(row_execute), 128'(0));
        chk("load_w_ready", 128'(w_ready), 128'(0));
        chk_held("load");
        chk("load_psum_in", 128'(row_psum_in), 128'(exp_pin));
        execs = 0; stalled = 0; cyc = 0;
        while (execs < steps && cyc < 600) begin
            tick();
            act_valid = !(execs == stall_at && stalled < stall_len);
            if (!act_valid) stalled++;
            act_data = AW'(execs * 37 + 5);
            #1;
            chk("exec_no_load", 128'(row_load), 128'(0));
            chk("exec_act_ready", 128'(act_ready), 128'(1));
            chk("exec_strobe", 128'(row_execute), 128'(act_valid));
            chk("exec_act", 128'(row_activation_flat), act_valid ? 128'(act_data) : 128'(0));
            chk("exec_psum_in", 128'(row_psum_in), 128'(exp_pin));
            if (act_valid) execs++;
            cyc++;
        end
        chk("exec_count", 128'(execs), 128'(steps));
        chk_held("exec");
        act_valid = 1'b1;
        for (int i = 0; i < int'(LT); i++) begin
            tick();
            chk("drain_no_res", 128'(res_valid), 128'(0));
            chk("drain_no_exec", 128'(row_execute), 128'(0));
            chk("drain_busy", 128'(busy), 128'(1));
        end
        tick();
        row_psum_out = ~psum;
        for (int i = 0; i < rdy_wait; i++) begin
            start = poke; num_steps = 8'd3;
            chk("out_wait_valid", 128'(res_valid), 128'(1));
            chk("out_wait_data", 128'(res_data), 128'(psum));
            chk("out_wait_no_done", 128'(done), 128'(0));
            tick();
        end
        start = 1'b0; num_steps = 8'd0; res_ready = 1'b1;
        chk("out_valid", 128'(res_valid), 128'(1));
        chk("out_data", 128'(res_data), 128'(psum));
        chk("out_no_exec", 128'(row_execute), 128'(0));
        chk("out_psum_in", 128'(row_psum_in), 128'(exp_pin));
        chk_held("out");
        tick();
        res_ready = 1'b0; act_valid = 1'b0;
        chk("done_pulse", 128'(done), 128'(1));
        chk("done_idle", 128'(busy), 128'(0));
        chk("done_res_low", 128'(res_valid), 128'(0));
        tick();
        chk("done_single", 128'(done), 128'(0));
        chk("idle_after", 128'(busy), 128'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_steps = 8'd0; accumulate = 1'b0;
        w_valid = 1'b0; w_data = '0; w_idx = '0; w_sel = '0; w_aidx = '0;
        act_valid = 1'b0; act_data = '0; row_psum_out = '0; res_ready = 1'b0;
        p1 = PSW'({$urandom, $urandom, $urandom});
        p2 = PSW'({$urandom, $urandom, $urandom});
        p3 = PSW'({$urandom, $urandom, $urandom}) | PSW'(1);
        p4 = PSW'({$urandom, $urandom, $urandom});
        p5 = PSW'({$urandom, $urandom, $urandom});
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_data", 128'(res_data), 128'(0));
        chk("rst_w_ready", 128'(w_ready), 128'(0));
        chk("rst_load", 128'(row_load), 128'(0));
        tick();

        // Zero-step job completes immediately without touching the row.
        start = 1'b1; num_steps = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_done", 128'(done), 128'(1));
        chk("zero_busy", 128'(busy), 128'(0));
        chk("zero_no_load", 128'(row_load), 128'(0));
        chk("zero_no_wreq", 128'(w_ready), 128'(0));
        tick();
        chk("zero_done_once", 128'(done), 128'(0));
        chk("zero_busy_later", 128'(busy), 128'(0));

        // Unstalled 4-step job; a stalled 4-step job accumulating job 1;
        // then a job with slow res_ready and start poked during OUT.
        run_job(4, 1'b0, -1, 0, 0, p1, '0, 1'b0);
        run_job(4, 1'b1, 2, 2, 0, p2, p1, 1'b0);
        run_job(3, 1'b0, -1, 0, 5, p3, '0, 1'b1);

        // Reset in the middle of EXEC.
        w_data = WDW'($urandom) | WDW'(1); w_idx = '1; w_sel = '1; w_aidx = '1;
        start = 1'b1; num_steps = 8'd6; w_valid = 1'b1; act_valid = 1'b1; act_data = 8'h5a;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_exec", 128'(row_execute), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_exec", 128'(row_execute), 128'(0));
        chk("mid_rst_act", 128'(row_activation_flat), 128'(0));
        chk("mid_rst_act_ready", 128'(act_ready), 128'(0));
        chk("mid_rst_w_ready", 128'(w_ready), 128'(0));
        chk("mid_rst_res_data", 128'(res_data), 128'(0));
        chk("mid_rst_psum_in", 128'(row_psum_in), 128'(0));
        chk("mid_rst_wd", 128'(row_weights_flat), 128'(0));
        chk("mid_rst_ws", 128'(row_a_select), 128'(0));
        chk("mid_rst_wi", 128'(row_w_index), 128'(0));
        chk("mid_rst_wa", 128'(row_activation_index_flat), 128'(0));
        for (int i = 0; i < 8; i++) begin
            chk("mid_rst_no_done", 128'(done), 128'(0));
            chk("mid_rst_no_res", 128'(res_valid), 128'(0));
            tick();
        end
        act_valid = 1'b0; w_valid = 1'b0;

        // Fresh job after reset accumulates the cleared result (zero),
        // then a maximum-length job.
        run_job(2, 1'b1, -1, 0, 0, p4, '0, 1'b0);
        run_job(255, 1'b1, -1, 0, 0, p5, p4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dp1m4_row_ctrl.md
DP1M4_ROW_CTRL -- requirements
Module: dp1m4_row_ctrl

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
  bw, 4, activation/weight element width
  psum_bw, 20, per-lane partial-sum width
  nnz, 2, non-zero weights per lane
  n, 4, one-hot weight-index width per lane
  M, 4, lanes in the row
  LAT, 2, row datapath cycles from last execute to valid psum_out
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all logic on its rising edge
  reset, in, 1, synchronous, active-high
  start, in, 1, begin one job; sampled only in IDLE
  num_steps, in, 8, activation steps per job; sampled with start
  accumulate, in, 1, 1: feed previous result as psum_in; 0: feed zero; sampled with start
  busy, out, 1, job in progress
  done, out, 1, one-cycle completion pulse
  w_valid / w_ready, in / out, 1 / 1, weight-packet handshake
  w_data, in, M*nnz*bw, packed weights
  w_idx, in, M*n, packed one-hot weight indices
  w_sel, in, M, per-lane a_select
  w_aidx, in, M*4, per-lane activation index
  act_valid / act_ready, in / out, 1 / 1, activation-stream handshake
  act_data, in, 2*bw, activation pair
  row_load, out, 1, load strobe to row
  row_execute, out, 1, execute strobe to row
  row_activation_flat, out, 2*bw, activation to row
  row_a_select, out, M, held w_sel
  row_weights_flat, out, M*nnz*bw, held w_data
  row_w_index, out, M*n, held w_idx
  row_activation_index_flat, out, M*4, held w_aidx
  row_psum_in, out, M*psum_bw, accumulate ? res_data : 0
  row_psum_out, in, M*psum_bw, row result
  res_valid / res_ready, out / in, 1 / 1, result handshake
  res_data, out, M*psum_bw, captured row_psum_out

Function
REQ-003 FSM states SHALL be IDLE, WREQ, LOAD, EXEC, DRAIN, OUT; busy=1 in every state except IDLE.
REQ-004 IDLE: start with num_steps!=0 SHALL latch num_steps and accumulate, go to WREQ; start with num_steps==0 SHALL pulse done next cycle and stay IDLE; start outside IDLE SHALL be ignored.
REQ-005 WREQ: w_ready=1; on w_valid SHALL capture w_data/w_idx/w_sel/w_aidx into holding registers and go to LOAD; otherwise stay.
REQ-006 LOAD: SHALL assert row_load for exactly one cycle with held weight fields, then go to EXEC.
REQ-007 EXEC: act_ready=1; row_execute SHALL equal act_valid; row_activation_flat SHALL pass act_data combinationally; each handshake increments step counter; handshake on step num_steps-1 SHALL go to DRAIN; act_valid low stalls without leaving EXEC.
REQ-008 row_activation_flat SHALL be zero when row_execute=0; row_load and row_execute SHALL never be high together.
REQ-009 DRAIN: SHALL last exactly LAT cycles; on its last cycle res_data SHALL capture row_psum_out; then go to OUT.
REQ-010 OUT: res_valid=1, res_data stable; on res_ready SHALL go to IDLE and pulse done the following cycle.
REQ-011 Latency with no stalls: start at cycle 0 -> WREQ handshake cycle 1, row_load cycle 2, execute cycles 3..2+S, res_valid from cycle 3+S+LAT.
REQ-012 Held weight registers and row_psum_in SHALL remain constant from LOAD through OUT.
REQ-013 Step and drain counters SHALL not wrap; num_steps=255 SHALL produce exactly 255 execute cycles.

Reset
REQ-014 reset SHALL, at the next edge and from any state, force IDLE and zero all outputs, holding registers, res_data and counters.
REQ-015 A job interrupted by reset SHALL produce no done and no res_valid.

Verification
REQ-016 S=4, LAT=2, valid always high, start at cycle 0 -> row_load at 2, row_execute 3..6, res_valid at 9, done one cycle after res handshake.
REQ-017 act_valid low two cycles mid-EXEC -> row_execute low those cycles, exactly 4 executes, res_valid delayed by 2.
REQ-018 start with num_steps=0 -> done pulse next cycle, busy never high, no row_load.
REQ-019 Job 2 with accumulate=1 after job 1 result R -> row_psum_in = R throughout job 2; accumulate=0 -> zero.
REQ-020 reset asserted in EXEC -> next cycle IDLE, all outputs zero, no done; start after reset runs a normal job.
REQ-021 res_ready held low 5 cycles in OUT, start pulsed meanwhile -> res_data stable, start ignored, single done.
